// File: rtl/multicycle_control_if.sv
// Bundle of instruction-register fields, ALU flag and datapath controls
// exchanged between the multicycle controller and its datapath.
interface multicycle_control_if;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       PCWrite;
  logic [1:0] PCSource;
  logic       InstrDone;
  logic       Illegal;
  logic [3:0] State;

  // datapath side: supplies instruction fields and flag, consumes controls
  modport master (
    output Opcode, Funct, Zero,
    input  ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCWrite, PCSource, InstrDone,
           Illegal, State
  );

  modport slave (
    input  Opcode, Funct, Zero,
    output ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, PCWrite, PCSource, InstrDone,
           Illegal, State
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute states
// and drives the datapath control lines for each state.
module multicycle_control (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXE  = 4'd6,  S_RTWB  = 4'd7,
    S_ITEXE  = 4'd8,  S_ITWB   = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_opcode;

  logic [2:0] w_aluop;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic       w_iord, w_memread, w_memwrite, w_irwrite;
  logic       w_regdst, w_memtoreg, w_regwrite, w_pcwrite;
  logic [1:0] w_pcsource;
  logic       w_instrdone, w_illegal;
  logic       w_unused_funct;

  // Funct is decoded downstream from ALUOp=111; it never steers sequencing.
  assign w_unused_funct = ^bus.Funct;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_opcode <= 6'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_opcode <= bus.Opcode;
    end
  end

  always_comb begin
    w_next      = S_FETCH;
    w_aluop     = 3'b000;
    w_alusrca   = 1'b0;
    w_alusrcb   = 2'b00;
    w_iord      = 1'b0;
    w_memread   = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regdst    = 1'b0;
    w_memtoreg  = 1'b0;
    w_regwrite  = 1'b0;
    w_pcwrite   = 1'b0;
    w_pcsource  = 2'b00;
    w_instrdone = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_irwrite = 1'b1;
        w_alusrcb = 2'b01;
        w_aluop   = 3'b100;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // the opcode latch is loaded this cycle, so decode the live field
        w_alusrcb = 2'b10;
        w_aluop   = 3'b100;
        case (bus.Opcode)
          OP_LW, OP_SW:           w_next = S_MEMADR;
          OP_RTYPE:               w_next = S_RTEXE;
          OP_ADDI, OP_ORI, OP_LUI: w_next = S_ITEXE;
          OP_BEQ, OP_BNE:         w_next = S_BRANCH;
          OP_J:                   w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = 3'b100;
        w_next    = (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
        w_next    = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite  = 1'b1;
        w_memtoreg  = 1'b1;
        w_instrdone = 1'b1;
      end
      S_MEMWR: begin
        w_memwrite  = 1'b1;
        w_iord      = 1'b1;
        w_instrdone = 1'b1;
      end
      S_RTEXE: begin
        w_alusrca = 1'b1;
        w_aluop   = 3'b111;
        w_next    = S_RTWB;
      end
      S_RTWB: begin
        w_regwrite  = 1'b1;
        w_regdst    = 1'b1;
        w_instrdone = 1'b1;
      end
      S_ITEXE: begin
        w_alusrca = 1'b1;
        w_next    = S_ITWB;
        case (r_opcode)
          OP_ORI: begin w_alusrcb = 2'b11; w_aluop = 3'b101; end
          OP_LUI: begin w_alusrcb = 2'b11; w_aluop = 3'b110; end
          default: begin w_alusrcb = 2'b10; w_aluop = 3'b100; end
        endcase
      end
      S_ITWB: begin
        w_regwrite  = 1'b1;
        w_instrdone = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca   = 1'b1;
        w_aluop     = 3'b001;
        w_pcsource  = 2'b01;
        w_instrdone = 1'b1;
        w_pcwrite   = (r_opcode == OP_BNE) ? ~bus.Zero : bus.Zero;
      end
      S_JUMP: begin
        w_pcsource  = 2'b10;
        w_pcwrite   = 1'b1;
        w_instrdone = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign bus.ALUOp     = w_aluop;
  assign bus.ALUSrcA   = w_alusrca;
  assign bus.ALUSrcB   = w_alusrcb;
  assign bus.IorD      = w_iord;
  assign bus.MemRead   = w_memread;
  assign bus.RegDst    = w_regdst;
  assign bus.MemtoReg  = w_memtoreg;
  assign bus.PCSource  = w_pcsource;
  assign bus.State     = r_state;
  // state-changing strobes are suppressed while reset is held
  assign bus.PCWrite   = w_pcwrite   & ~reset;
  assign bus.IRWrite   = w_irwrite   & ~reset;
  assign bus.MemWrite  = w_memwrite  & ~reset;
  assign bus.RegWrite  = w_regwrite  & ~reset;
  assign bus.InstrDone = w_instrdone & ~reset;
  assign bus.Illegal   = w_illegal   & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares state and the full control word per cycle.
module tb_multicycle_control;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [3:0] exp_q[$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // {Illegal, InstrDone, PCSource, PCWrite, RegWrite, MemtoReg, RegDst,
  //  IRWrite, MemWrite, MemRead, IorD, ALUSrcB, ALUSrcA, ALUOp}
  logic [17:0] w_ctrl;
  assign w_ctrl = {bus.Illegal, bus.InstrDone, bus.PCSource, bus.PCWrite,
                   bus.RegWrite, bus.MemtoReg, bus.RegDst, bus.IRWrite,
                   bus.MemWrite, bus.MemRead, bus.IorD, bus.ALUSrcB,
                   bus.ALUSrcA, bus.ALUOp};

  localparam logic [17:0] RST_MASK = ~(18'(1) << 17 | 18'(1) << 16 | 18'(1) << 13 |
                                       18'(1) << 12 | 18'(1) << 9  | 18'(1) << 8);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                           input logic z);
    logic [2:0] aluop;
    logic       srca, iord, mr, mw, irw, rd, m2r, rw, pcw, done, ill;
    logic [1:0] srcb, pcs;
    aluop = 3'b000; srca = 0; srcb = 2'b00; pcs = 2'b00;
    iord = 0; mr = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; pcw = 0;
    done = 0; ill = 0;
    case (st)
      4'd0:  begin mr = 1; irw = 1; srcb = 2'b01; aluop = 3'b100; pcw = 1; end
      4'd1:  begin
        srcb = 2'b10; aluop = 3'b100;
        ill = !(op inside {6'b000000, 6'b001000, 6'b001101, 6'b001111, 6'b100011,
                           6'b101011, 6'b000100, 6'b000101, 6'b000010});
      end
      4'd2:  begin srca = 1; srcb = 2'b10; aluop = 3'b100; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; done = 1; end
      4'd5:  begin mw = 1; iord = 1; done = 1; end
      4'd6:  begin srca = 1; aluop = 3'b111; end
      4'd7:  begin rw = 1; rd = 1; done = 1; end
      4'd8:  begin
        srca = 1;
        if (op == 6'b001101)      begin srcb = 2'b11; aluop = 3'b101; end
        else if (op == 6'b001111) begin srcb = 2'b11; aluop = 3'b110; end
        else                      begin srcb = 2'b10; aluop = 3'b100; end
      end
      4'd9:  begin rw = 1; done = 1; end
      4'd10: begin srca = 1; aluop = 3'b001; pcs = 2'b01; done = 1;
                   pcw = (op == 6'b000101) ? ~z : z; end
      4'd11: begin pcs = 2'b10; pcw = 1; done = 1; end
      default: ;
    endcase
    return {ill, done, pcs, pcw, rw, m2r, rd, irw, mw, mr, iord, srcb, srca, aluop};
  endfunction

  // driver: called at posedge+1 in FETCH; pops the expected state sequence
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int exp_done);
    logic [3:0] st;
    int done_cnt;
    done_cnt = 0;
    bus.Opcode = op;
    bus.Funct  = fn;
    bus.Zero   = z;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      st = exp_q.pop_front();
      check({name, "_state"}, 32'(bus.State), 32'(st));
      check({name, "_ctrl"}, 32'(w_ctrl), 32'(exp_ctrl(st, op, z)));
      if (bus.InstrDone) done_cnt++;
      @(posedge clk);
      #1;
    end
    check({name, "_donecnt"}, 32'(done_cnt), 32'(exp_done));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.Opcode = 6'd0;
    bus.Funct  = 6'd0;
    bus.Zero   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(bus.State), 32'd0);
    check("rst_ctrl", 32'(w_ctrl), 32'(exp_ctrl(4'd0, 6'd0, 1'b0) & RST_MASK));
    check("rst_opcode", 32'(dut.r_opcode), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    run_instr("lw", 6'b100011, 6'd0, 1'b0, 1);
    exp_q = '{4'd0, 4'd1, 4'd6, 4'd7};
    run_instr("radd", 6'b000000, 6'b100000, 1'b0, 1);
    exp_q = '{4'd0, 4'd1, 4'd6, 4'd7};
    run_instr("rsub", 6'b000000, 6'b100010, 1'b1, 1);
    exp_q = '{4'd0, 4'd1, 4'd10};
    run_instr("beq_z1", 6'b000100, 6'd0, 1'b1, 1);
    exp_q = '{4'd0, 4'd1, 4'd10};
    run_instr("bne_z1", 6'b000101, 6'd0, 1'b1, 1);
    exp_q = '{4'd0, 4'd1, 4'd10};
    run_instr("beq_z0", 6'b000100, 6'd0, 1'b0, 1);
    exp_q = '{4'd0, 4'd1, 4'd10};
    run_instr("bne_z0", 6'b000101, 6'd0, 1'b0, 1);
    exp_q = '{4'd0, 4'd1, 4'd8, 4'd9};
    run_instr("ori", 6'b001101, 6'd0, 1'b0, 1);
    exp_q = '{4'd0, 4'd1, 4'd8, 4'd9};
    run_instr("lui", 6'b001111, 6'd0, 1'b0, 1);
    exp_q = '{4'd0, 4'd1, 4'd8, 4'd9};
    run_instr("addi", 6'b001000, 6'd0, 1'b0, 1);
    exp_q = '{4'd0, 4'd1, 4'd11};
    run_instr("j", 6'b000010, 6'd0, 1'b0, 1);
    exp_q = '{4'd0, 4'd1};
    run_instr("ill", 6'b111111, 6'd0, 1'b0, 0);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd5};
    run_instr("sw", 6'b101011, 6'd0, 1'b0, 1);

    // sw interrupted by reset while in MEMADR
    bus.Opcode = 6'b101011;
    @(negedge clk);
    check("swr_fetch", 32'(bus.State), 32'd0);
    @(negedge clk);
    check("swr_decode", 32'(bus.State), 32'd1);
    @(negedge clk);
    check("swr_memadr", 32'(bus.State), 32'd2);
    check("swr_latched", 32'(dut.r_opcode), 32'(6'b101011));
    reset = 1'b1;
    #1;
    check("swr_mw_memadr", 32'(bus.MemWrite), 32'd0);
    @(posedge clk);
    #1;
    check("swr_state_after", 32'(bus.State), 32'd0);
    check("swr_opcode_clr", 32'(dut.r_opcode), 32'd0);
    check("swr_ctrl_rst", 32'(w_ctrl), 32'(exp_ctrl(4'd0, 6'd0, 1'b0) & RST_MASK));
    reset = 1'b0;

    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    run_instr("lw2", 6'b100011, 6'd0, 1'b0, 1);
    @(negedge clk);
    check("final_fetch", 32'(bus.State), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters; state encoding is fixed per REQ-015.
REQ-002 clk  in  1  single clock; all state updates occur on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Opcode  in  6  instruction[31:26] from the instruction register.
REQ-005 Funct  in  6  instruction[5:0] from the instruction register.
REQ-006 Zero  in  1  ALU zero flag of the current cycle.
REQ-007 ALUOp  out  3  ALU-control code: 100 add, 101 or, 110 lui, 001 subtract/branch, 111 R-type (funct-decoded).
REQ-008 ALUSrcA  out  1  0 = PC, 1 = register A.
REQ-009 ALUSrcB  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = zero-extended immediate.
REQ-010 IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCWrite  out  1 each  standard multicycle datapath controls.
REQ-011 PCSource  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-012 InstrDone  out  1  one-cycle pulse in the last state of each instruction.
REQ-013 Illegal  out  1  one-cycle pulse in DECODE when Opcode is unsupported.
REQ-014 State  out  4  current state code, for debug.

Function
REQ-015 SHALL use state codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, ITEXE=8, ITWB=9, BRANCH=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-016 SHALL support opcodes: 000000 R-type, 001000 addi, 001101 ori, 001111 lui, 100011 lw, 101011 sw, 000100 beq, 000101 bne, 000010 j.
REQ-017 SHALL latch Opcode into an internal register on the DECODE cycle; all later states SHALL use the latched copy.
REQ-018 FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00, PCWrite=1; next state = DECODE.
REQ-019 DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=100 (branch-target precompute); next state = MEMADR for lw/sw, RTEXE for R-type, ITEXE for addi/ori/lui, BRANCH for beq/bne, JUMP for j; any other opcode SHALL assert Illegal and go to FETCH.
REQ-020 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=100; next state = MEMRD for lw, MEMWR for sw.
REQ-021 MEMRD: MemRead=1, IorD=1; next state = MEMWB. MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1; next state = FETCH.
REQ-022 MEMWR: MemWrite=1, IorD=1, InstrDone=1; next state = FETCH.
REQ-023 RTEXE: ALUSrcA=1, ALUSrcB=00, ALUOp=111; next state = RTWB. RTWB: RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1; next state = FETCH.
REQ-024 ITEXE: ALUSrcA=1; addi: ALUSrcB=10, ALUOp=100; ori: ALUSrcB=11, ALUOp=101; lui: ALUSrcB=11, ALUOp=110; next state = ITWB. ITWB: RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1; next state = FETCH.
REQ-025 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, InstrDone=1; PCWrite SHALL equal Zero for beq and ~Zero for bne in the same cycle (only Zero-dependent output); next state = FETCH.
REQ-026 JUMP: PCSource=10, PCWrite=1, InstrDone=1; next state = FETCH.
REQ-027 Any control not listed for a state SHALL be 0 (ALUOp 000, ALUSrcB 00, PCSource 00).
REQ-028 Latency in cycles, FETCH to FETCH: lw 5; sw, R-type, addi, ori, lui 4; beq, bne, j 3; illegal 2.
REQ-029 Funct SHALL NOT alter sequencing; it is decoded downstream via ALUOp=111.

Reset
REQ-030 reset high at a rising edge SHALL load State=FETCH and clear the latched opcode to 0, regardless of current state (including mid-instruction).
REQ-031 While reset is high, PCWrite, IRWrite, MemWrite, RegWrite, InstrDone and Illegal SHALL be forced to 0 combinationally; the other outputs follow the state.
REQ-032 After reset deasserts, the first cycle SHALL be FETCH with REQ-018 outputs.

Verification
REQ-033 Reset, then Opcode=100011 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; InstrDone pulses once.
REQ-034 Opcode=000000, Funct=100000 -> states 0,1,6,7,0; ALUOp=111 in state 6; RegDst=1 and RegWrite=1 in state 7.
REQ-035 Opcode=000100 with Zero=1, then Opcode=000101 with Zero=1 -> PCWrite=1 in the first BRANCH cycle, 0 in the second; each takes 3 cycles.
REQ-036 Opcode=001101 -> ITEXE shows ALUSrcB=11, ALUOp=101; Opcode=001111 -> ALUSrcB=11, ALUOp=110.
REQ-037 Opcode=111111 -> Illegal=1 in DECODE, then FETCH; no RegWrite or MemWrite asserted.
REQ-038 Opcode=101011 with reset asserted during MEMADR -> next state FETCH, MemWrite never 1, latched opcode reads 0.
